// File: rtl/iddmm_pkg.sv
// Shared definitions for the Montgomery multiplier task driver.
//   state_e        : driver FSM states
//   WR_X/WR_Y/WR_M : bit positions of the operand-RAM write enables in wr_ena
//   DEF_*          : default word size, word count and watchdog limit
package iddmm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_COLLECT,
      ST_DONE
   } state_e;

   localparam int WR_X = 0;
   localparam int WR_Y = 1;
   localparam int WR_M = 2;

   localparam int DEF_K       = 128;
   localparam int DEF_N       = 32;
   localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/iddmm_res_deser.sv
// Word-indexed result collector.
// Each enabled cycle stores word_i into slot cnt and advances cnt; once N
// words are held the collector is full and ignores further words until
// cleared.
//   clk, rst  : clock, synchronous active-high reset (counter only)
//   clr_i     : restart collection at slot 0
//   en_i      : word_i is valid this cycle
//   word_i    : K-bit result word, LSW first
//   data_o    : N*K assembled result, word 0 in bits [K-1:0]
//   cnt_o     : number of words stored so far (0..N)
//   full_o    : all N words stored
module iddmm_res_deser
   import iddmm_pkg::*;
#(
   parameter int K      = DEF_K,
   parameter int N      = DEF_N,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [K-1:0]      word_i,
   output logic [N*K-1:0]    data_o,
   output logic [ADDR_W:0]   cnt_o,
   output logic              full_o
);

   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [N*K-1:0]  data_q;

   assign full_o = (cnt_q == (ADDR_W+1)'(N));
   assign cnt_o  = cnt_q;
   assign data_o = data_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !full_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Data slots carry no reset; they are only read once all N are written.
   always_ff @(posedge clk) begin
      if (en_i && !full_o && !clr_i) begin
         data_q[int'(cnt_q[ADDR_W-1:0])*K +: K] <= word_i;
      end
   end

endmodule

// File: rtl/iddmm_task_driver.sv
// Initiator side of the Montgomery multiplier task interface.
// Accepts a full-width operand set, writes it word by word into the
// multiplier operand RAMs, requests a task, gathers the N result words and
// returns the full-width product. A watchdog aborts a task that stalls in
// request or collection for TIMEOUT cycles, returning res_err with zero data.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_x, in_y, in_m, in_m1, in_load_m)
//   res_valid/res_ready : result handshake (res_data, res_err)
//   wr_ena/wr_addr      : operand RAM write strobe {m,y,x} and word address
//   wr_x/wr_y/wr_m      : operand word data, zero when not written
//   wr_m1               : captured m1, stable for the task
//   task_req/task_grant : task request and one-cycle grant
//   task_end/task_res   : result word strobe and data, LSW first
module iddmm_task_driver
   import iddmm_pkg::*;
#(
   parameter int K       = DEF_K,
   parameter int N       = DEF_N,
   parameter int ADDR_W  = $clog2(N),
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*K-1:0]    in_x,
   input  logic [N*K-1:0]    in_y,
   input  logic [N*K-1:0]    in_m,
   input  logic [K-1:0]      in_m1,
   input  logic              in_load_m,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N*K-1:0]    res_data,
   output logic              res_err,
   output logic [2:0]        wr_ena,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [K-1:0]      wr_x,
   output logic [K-1:0]      wr_y,
   output logic [K-1:0]      wr_m,
   output logic [K-1:0]      wr_m1,
   output logic              task_req,
   input  logic              task_grant,
   input  logic              task_end,
   input  logic [K-1:0]      task_res
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_e              state_q;
   logic                in_ready_q;
   logic [2:0]          wr_ena_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic                task_req_q;
   logic                res_valid_q;
   logic                res_err_q;
   logic                m_loaded_q;
   logic                load_m_q;
   logic [WD_W-1:0]     wd_q;
   logic [K-1:0]        m1_q;
   logic [N*K-1:0]      x_q, y_q, m_q;

   logic                accept;
   logic                load_m_eff;
   logic                res_en;
   logic                last_word;
   logic                wd_expired;
   logic [N*K-1:0]      deser_data;
   logic [ADDR_W:0]     deser_cnt;
   logic                deser_full;

   assign accept     = (state_q == ST_IDLE) && in_valid;
   assign load_m_eff = in_load_m | ~m_loaded_q;
   // A word arriving with the grant belongs to the task just granted.
   assign res_en     = task_end && !deser_full &&
                       (((state_q == ST_REQ) && task_grant) || (state_q == ST_COLLECT));
   assign last_word  = res_en && (deser_cnt == (ADDR_W+1)'(N - 1));
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   iddmm_res_deser #(
      .K      (K),
      .N      (N),
      .ADDR_W (ADDR_W)
   ) u_res_deser (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .en_i   (res_en),
      .word_i (task_res),
      .data_o (deser_data),
      .cnt_o  (deser_cnt),
      .full_o (deser_full)
   );

   // Operand capture; m is only consumed when the m RAM is rewritten.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_q <= in_x;
         y_q <= in_y;
         m_q <= in_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         wr_ena_q    <= '0;
         wr_addr_q   <= '0;
         task_req_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         m_loaded_q  <= 1'b0;
         load_m_q    <= 1'b0;
         wd_q        <= '0;
         m1_q        <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  m1_q           <= in_m1;
                  load_m_q       <= load_m_eff;
                  in_ready_q     <= 1'b0;
                  wr_addr_q      <= '0;
                  wr_ena_q[WR_X] <= 1'b1;
                  wr_ena_q[WR_Y] <= 1'b1;
                  wr_ena_q[WR_M] <= load_m_eff;
                  state_q        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (wr_addr_q == ADDR_W'(N - 1)) begin
                  wr_ena_q   <= '0;
                  wr_addr_q  <= '0;
                  m_loaded_q <= m_loaded_q | load_m_q;
                  task_req_q <= 1'b1;
                  wd_q       <= '0;
                  state_q    <= ST_REQ;
               end else begin
                  wr_addr_q <= wr_addr_q + 1'b1;
               end
            end
            ST_REQ, ST_COLLECT: begin
               if (wd_q != WD_W'(TIMEOUT)) begin
                  wd_q <= wd_q + 1'b1;
               end
               // Progress wins over the watchdog when both land together.
               if (state_q == ST_REQ && task_grant) begin
                  task_req_q <= 1'b0;
                  state_q    <= ST_COLLECT;
               end else if (state_q == ST_COLLECT && last_word) begin
                  res_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else if (wd_expired) begin
                  task_req_q  <= 1'b0;
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  res_err_q   <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign wr_ena    = wr_ena_q;
   assign wr_addr   = wr_addr_q;
   assign wr_m1     = m1_q;
   assign task_req  = task_req_q;
   assign res_valid = res_valid_q;
   assign res_err   = res_err_q;

   // Data outputs read zero whenever they are not qualified.
   assign wr_x     = wr_ena_q[WR_X] ? x_q[int'(wr_addr_q)*K +: K] : '0;
   assign wr_y     = wr_ena_q[WR_Y] ? y_q[int'(wr_addr_q)*K +: K] : '0;
   assign wr_m     = wr_ena_q[WR_M] ? m_q[int'(wr_addr_q)*K +: K] : '0;
   assign res_data = (res_valid_q && !res_err_q) ? deser_data : '0;

endmodule

// File: tb/tb_iddmm_task_driver.sv
module tb_iddmm_task_driver;

   localparam int K       = 8;
   localparam int N       = 4;
   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [N*K-1:0]    in_x, in_y, in_m;
   logic [K-1:0]      in_m1;
   logic              in_load_m;
   logic              res_valid;
   logic              res_ready;
   logic [N*K-1:0]    res_data;
   logic              res_err;
   logic [2:0]        wr_ena;
   logic [ADDR_W-1:0] wr_addr;
   logic [K-1:0]      wr_x, wr_y, wr_m, wr_m1;
   logic              task_req;
   logic              task_grant;
   logic              task_end;
   logic [K-1:0]      task_res;

   int checks = 0;
   int errors = 0;

   iddmm_task_driver #(
      .K       (K),
      .N       (N),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_m       (in_m),
      .in_m1      (in_m1),
      .in_load_m  (in_load_m),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .wr_ena     (wr_ena),
      .wr_addr    (wr_addr),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_m       (wr_m),
      .wr_m1      (wr_m1),
      .task_req   (task_req),
      .task_grant (task_grant),
      .task_end   (task_end),
      .task_res   (task_res)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] m, input logic [7:0] m1, input logic lm);
      in_x      = x;
      in_y      = y;
      in_m      = m;
      in_m1     = m1;
      in_load_m = lm;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_m      = '0;
      in_m1     = '0;
   endtask

   logic [7:0] wds [4];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_m = '0; in_m1 = '0;
      in_load_m = 1'b0; res_ready = 1'b0; task_grant = 1'b0; task_end = 1'b0; task_res = '0;
      wds[0] = 8'hA1; wds[1] = 8'hB2; wds[2] = 8'hC3; wds[3] = 8'hD4;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_ena", wr_ena, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_x", wr_x, 0);
      chk("rst_wr_m1", wr_m1, 0);
      chk("rst_task_req", task_req, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_res_data", res_data, 0);

      // Task 1: full load, stray task_end in REQ, gapped collection
      start(32'h44332211, 32'h88776655, 32'hFFEEDDCC, 8'h5A, 1'b1);
      chk("t1_in_ready_low", in_ready, 0);
      chk("t1_wr_m1", wr_m1, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         chk("t1_wr_ena", wr_ena, 3'b111);
         chk("t1_wr_addr", wr_addr, i);
         chk("t1_wr_x", wr_x, 8'h11 * (i + 1));
         chk("t1_wr_y", wr_y, 8'h55 + 8'h11 * i);
         chk("t1_wr_m", wr_m, 8'hCC + 8'h11 * i);
         tick();
      end
      chk("t1_wr_ena_off", wr_ena, 0);
      chk("t1_task_req", task_req, 1);
      for (int j = 0; j < 5; j++) begin
         if (j == 2) begin
            task_end = 1'b1;
            task_res = 8'hEE;
         end
         tick();
         task_end = 1'b0;
         chk("t1_req_hold", task_req, 1);
      end
      task_grant = 1'b1;
      tick();
      task_grant = 1'b0;
      chk("t1_req_drop", task_req, 0);
      for (int w = 0; w < 4; w++) begin
         task_end = 1'b1;
         task_res = wds[w];
         tick();
         task_end = 1'b0;
         if (w < 3) begin
            chk("t1_no_valid_yet", res_valid, 0);
            tick();
            tick();
         end
      end
      chk("t1_res_valid", res_valid, 1);
      chk("t1_res_err", res_err, 0);
      chk("t1_res_data", res_data, 32'hD4C3B2A1);
      chk("t1_in_ready_done", in_ready, 0);
      for (int h = 0; h < 3; h++) begin
         tick();
         chk("t1_hold_data", res_data, 32'hD4C3B2A1);
         chk("t1_hold_valid", res_valid, 1);
         chk("t1_hold_in_ready", in_ready, 0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t1_valid_clear", res_valid, 0);
      chk("t1_in_ready_back", in_ready, 1);
      chk("t1_data_clear", res_data, 0);

      // Task 2: reuse m, word 0 arrives with the grant
      start(32'h04030201, 32'h08070605, 32'h0C0B0A09, 8'h33, 1'b0);
      chk("t2_wr_ena", wr_ena, 3'b011);
      chk("t2_wr_m_zero", wr_m, 0);
      chk("t2_wr_x", wr_x, 8'h01);
      repeat (4) tick();
      chk("t2_task_req", task_req, 1);
      task_grant = 1'b1; task_end = 1'b1; task_res = 8'h10;
      tick();
      task_grant = 1'b0; task_res = 8'h20;
      tick();
      task_res = 8'h30;
      tick();
      chk("t2_no_valid_yet", res_valid, 0);
      task_res = 8'h40;
      tick();
      task_end = 1'b0;
      chk("t2_res_valid", res_valid, 1);
      chk("t2_res_data", res_data, 32'h40302010);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Task 3: reset in the middle of LOAD
      start(32'h11111111, 32'h22222222, 32'h33333333, 8'h01, 1'b0);
      chk("t3_wr_ena", wr_ena, 3'b011);
      tick();
      tick();
      chk("t3_wr_addr", wr_addr, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t3_rst_wr_ena", wr_ena, 0);
      chk("t3_rst_in_ready", in_ready, 1);
      chk("t3_rst_task_req", task_req, 0);

      // Task 4: m_loaded cleared by reset, then watchdog abort
      start(32'h55555555, 32'h66666666, 32'h77777777, 8'h02, 1'b0);
      chk("t4_wr_ena", wr_ena, 3'b111);
      chk("t4_wr_m", wr_m, 8'h77);
      repeat (4) tick();
      chk("t4_task_req", task_req, 1);
      for (int j = 1; j < 16; j++) begin
         tick();
         chk("t4_req_hold", task_req, 1);
      end
      tick();
      chk("t4_req_timeout", task_req, 0);
      chk("t4_res_valid", res_valid, 1);
      chk("t4_res_err", res_err, 1);
      chk("t4_res_data", res_data, 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t4_in_ready", in_ready, 1);
      chk("t4_err_clear", res_err, 0);

      // Task 5: m_loaded survives the timeout
      start(32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 8'h03, 1'b0);
      chk("t5_wr_ena", wr_ena, 3'b011);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
